// File: rtl/mem_lsu_if.sv
// ============================================================================
// mem_lsu_if : single-outstanding req/ack data bus between LSU and memory
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, we, addr, wdata, sel, input rdata, ack);
    modport slave  (input req, we, addr, wdata, sel, output rdata, ack);
endinterface

`default_nettype wire

// File: rtl/mem_lsu.sv
// ============================================================================
// mem_lsu : RV32I memory stage and mem_wb register (loads/stores over req/ack)
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_lsu #(
    parameter int TIMEOUT     = 255,
    parameter int RADDR_WIDTH = 5
) (
    input  wire logic                   clk_i,
    input  wire logic                   rst_i,
    input  wire logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  wire logic                   reg_we_i,
    input  wire logic [31:0]            reg_wdata_i,
    input  wire logic                   mem_we_i,
    input  wire logic [31:0]            mem_addr_i,
    input  wire logic [31:0]            mem_data_i,
    input  wire logic [3:0]             mem_op_i,
    mem_lsu_if.master                   bus,
    output logic                        stallreq_o,
    output logic [RADDR_WIDTH-1:0]      reg_waddr_o,
    output logic                        reg_we_o,
    output logic [31:0]                 reg_wdata_o,
    output logic                        misalign_o,
    output logic                        bus_err_o
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        lat_addr, lat_wdata;
    logic [3:0]         lat_sel;
    logic               lat_we;
    logic [3:0]         lat_op;
    logic [1:0]         lat_off;

    logic               is_load, is_store, sz_byte, sz_half, sz_word;
    logic               misaligned, access;
    logic [3:0]         sel_nxt;
    logic [31:0]        wdata_nxt, load_data;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;

    logic               start, take_result, abort, mis_evt;
    logic               wb_we;
    logic [RADDR_WIDTH-1:0] wb_waddr;
    logic [31:0]        wb_wdata;

    logic               unused_inputs;
    assign unused_inputs = mem_we_i;

    // Access decode; unknown opcodes fall through as NOP.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sz_byte  = 1'b0;
        sz_half  = 1'b0;
        sz_word  = 1'b0;
        case (mem_op_i)
            OP_LB, OP_LBU: begin is_load  = 1'b1; sz_byte = 1'b1; end
            OP_LH, OP_LHU: begin is_load  = 1'b1; sz_half = 1'b1; end
            OP_LW:         begin is_load  = 1'b1; sz_word = 1'b1; end
            OP_SB:         begin is_store = 1'b1; sz_byte = 1'b1; end
            OP_SH:         begin is_store = 1'b1; sz_half = 1'b1; end
            OP_SW:         begin is_store = 1'b1; sz_word = 1'b1; end
            default: ;
        endcase
        access     = is_load | is_store;
        misaligned = (sz_half & mem_addr_i[0]) | (sz_word & (|mem_addr_i[1:0]));
    end

    always_comb begin
        sel_nxt   = 4'b1111;
        wdata_nxt = mem_data_i;
        if (sz_byte) begin
            sel_nxt   = 4'b0001 << mem_addr_i[1:0];
            wdata_nxt = {4{mem_data_i[7:0]}};
        end else if (sz_half) begin
            sel_nxt   = mem_addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_nxt = {2{mem_data_i[15:0]}};
        end
        if (!is_store) begin
            wdata_nxt = 32'd0;
        end
    end

    always_comb begin
        case (lat_off)
            2'd0:    ld_byte = bus.rdata[7:0];
            2'd1:    ld_byte = bus.rdata[15:8];
            2'd2:    ld_byte = bus.rdata[23:16];
            default: ld_byte = bus.rdata[31:24];
        endcase
        ld_half = lat_off[1] ? bus.rdata[31:16] : bus.rdata[15:0];
        case (lat_op)
            OP_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  load_data = {24'd0, ld_byte};
            OP_LH:   load_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  load_data = {16'd0, ld_half};
            default: load_data = bus.rdata;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        stallreq_o  = 1'b0;
        start       = 1'b0;
        take_result = 1'b0;
        abort       = 1'b0;
        mis_evt     = 1'b0;
        wb_we       = 1'b0;
        wb_waddr    = '0;
        wb_wdata    = 32'd0;
        case (state)
            IDLE: begin
                if (!access) begin
                    wb_we    = reg_we_i;
                    wb_waddr = reg_waddr_i;
                    wb_wdata = reg_wdata_i;
                end else if (misaligned) begin
                    mis_evt = 1'b1;
                end else begin
                    start      = 1'b1;
                    stallreq_o = 1'b1;
                    state_nxt  = WAIT;
                end
            end
            WAIT: begin
                // Ack takes priority over a coincident timeout.
                if (bus.ack) begin
                    take_result = 1'b1;
                    state_nxt   = IDLE;
                    if (!lat_we) begin
                        wb_we    = reg_we_i;
                        wb_waddr = reg_waddr_i;
                        wb_wdata = load_data;
                    end
                end else if (cnt == CNT_LAST) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    stallreq_o = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (rst_i) begin
            stallreq_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt         <= '0;
            lat_addr    <= 32'd0;
            lat_wdata   <= 32'd0;
            lat_sel     <= 4'd0;
            lat_we      <= 1'b0;
            lat_op      <= 4'd0;
            lat_off     <= 2'd0;
            reg_we_o    <= 1'b0;
            reg_waddr_o <= '0;
            reg_wdata_o <= 32'd0;
            misalign_o  <= 1'b0;
            bus_err_o   <= 1'b0;
        end else begin
            cnt <= (state == WAIT && state_nxt == WAIT) ? cnt + 1'b1 : '0;
            if (start) begin
                lat_addr  <= {mem_addr_i[31:2], 2'b00};
                lat_wdata <= wdata_nxt;
                lat_sel   <= sel_nxt;
                lat_we    <= is_store;
                lat_op    <= mem_op_i;
                lat_off   <= mem_addr_i[1:0];
            end
            reg_we_o    <= wb_we;
            reg_waddr_o <= wb_waddr;
            reg_wdata_o <= wb_wdata;
            misalign_o  <= mis_evt;
            bus_err_o   <= abort;
        end
    end

    assign bus.req   = (state == WAIT);
    assign bus.we    = lat_we;
    assign bus.addr  = lat_addr;
    assign bus.wdata = lat_wdata;
    assign bus.sel   = lat_sel;

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
// ============================================================================
// tb_mem_lsu : directed scoreboard bench for the memory stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_lsu;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  reg_waddr_i;
    logic        reg_we_i;
    logic [31:0] reg_wdata_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [3:0]  mem_op_i;
    logic        stallreq;
    logic [4:0]  reg_waddr_o;
    logic        reg_we_o;
    logic [31:0] reg_wdata_o;
    logic        misalign;
    logic        bus_err;

    mem_lsu_if bus ();

    mem_lsu #(.TIMEOUT(TO), .RADDR_WIDTH(5)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .reg_waddr_i (reg_waddr_i),
        .reg_we_i    (reg_we_i),
        .reg_wdata_i (reg_wdata_i),
        .mem_we_i    (mem_we_i),
        .mem_addr_i  (mem_addr_i),
        .mem_data_i  (mem_data_i),
        .mem_op_i    (mem_op_i),
        .bus         (bus.master),
        .stallreq_o  (stallreq),
        .reg_waddr_o (reg_waddr_o),
        .reg_we_o    (reg_we_o),
        .reg_wdata_o (reg_wdata_o),
        .misalign_o  (misalign),
        .bus_err_o   (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        mis;
        logic        err;
        logic        full;
    } wb_t;

    wb_t sb[$];
    int  errors = 0;
    int  checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_wb(input string tag);
        wb_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s.scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".we"}, 32'(reg_we_o), 32'(e.we));
            if (e.full) begin
                chk({tag, ".waddr"}, 32'(reg_waddr_o), 32'(e.waddr));
                chk({tag, ".wdata"}, reg_wdata_o, e.wdata);
            end
            chk({tag, ".misalign"}, 32'(misalign), 32'(e.mis));
            chk({tag, ".bus_err"}, 32'(bus_err), 32'(e.err));
        end
    endtask

    // One op from issue to write-back; ack_k = WAIT cycle carrying ack (0 = never).
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input logic we, input logic [4:0] wa,
                          input logic [31:0] alu, input int ack_k, input logic [31:0] rdata,
                          input logic bus_exp, input logic bwe_exp, input logic [3:0] sel_exp,
                          input logic [31:0] wd_exp, input wb_t e);
        logic [31:0] waddr_exp;
        logic        last;
        waddr_exp = {addr[31:2], 2'b00};
        sb.push_back(e);
        mem_op_i    = op;
        mem_addr_i  = addr;
        mem_data_i  = data;
        mem_we_i    = (op >= 4'd6 && op <= 4'd8);
        reg_we_i    = we;
        reg_waddr_i = wa;
        reg_wdata_i = alu;
        #1;
        chk({tag, ".stall0"}, 32'(stallreq), 32'(bus_exp));
        @(posedge clk); #1;
        if (bus_exp) begin
            for (int k = 1; k <= TO; k++) begin
                chk({tag, ".req"}, 32'(bus.req), 32'd1);
                chk({tag, ".addr"}, bus.addr, waddr_exp);
                chk({tag, ".sel"}, 32'(bus.sel), 32'(sel_exp));
                chk({tag, ".bus_we"}, 32'(bus.we), 32'(bwe_exp));
                if (bwe_exp) chk({tag, ".bus_wdata"}, bus.wdata, wd_exp);
                last = (k == ack_k) || (k == TO);
                if (k == ack_k) begin
                    bus.ack   = 1'b1;
                    bus.rdata = rdata;
                end
                #1;
                chk({tag, ".stall"}, 32'(stallreq), 32'(!last));
                @(posedge clk); #1;
                bus.ack   = 1'b0;
                bus.rdata = 32'd0;
                if (last) break;
            end
        end
        chk({tag, ".req_after"}, 32'(bus.req), 32'd0);
        check_wb(tag);
    endtask

    initial begin
        rst = 1'b1;
        reg_waddr_i = '0; reg_we_i = 1'b0; reg_wdata_i = '0;
        mem_we_i = 1'b0; mem_addr_i = '0; mem_data_i = '0; mem_op_i = 4'd0;
        bus.ack = 1'b0; bus.rdata = '0;
        @(posedge clk); #1;
        mem_op_i = 4'd3;
        @(posedge clk); #1;
        chk("reset.stall", 32'(stallreq), 32'd0);
        chk("reset.req", 32'(bus.req), 32'd0);
        chk("reset.sel", 32'(bus.sel), 32'd0);
        chk("reset.we", 32'(reg_we_o), 32'd0);
        chk("reset.wdata", reg_wdata_o, 32'd0);
        chk("reset.flags", {30'd0, misalign, bus_err}, 32'd0);
        rst = 1'b0;
        mem_op_i = 4'd0;

        run_op("alu", 4'd0, 32'h0, 32'h0, 1'b1, 5'd5, 32'h1234, 0, 32'h0,
               1'b0, 1'b0, 4'h0, 32'h0, wb_t'{1'b1, 5'd5, 32'h1234, 1'b0, 1'b0, 1'b1});
        run_op("lb", 4'd1, 32'h1003, 32'h0, 1'b1, 5'd7, 32'hDEAD, 3, 32'h80FF_FFFF,
               1'b1, 1'b0, 4'b1000, 32'h0, wb_t'{1'b1, 5'd7, 32'hFFFF_FF80, 1'b0, 1'b0, 1'b1});
        run_op("lbu", 4'd4, 32'h1003, 32'h0, 1'b1, 5'd7, 32'hDEAD, 3, 32'h80FF_FFFF,
               1'b1, 1'b0, 4'b1000, 32'h0, wb_t'{1'b1, 5'd7, 32'h0000_0080, 1'b0, 1'b0, 1'b1});
        run_op("sh", 4'd7, 32'h2002, 32'hABCD_5678, 1'b1, 5'd8, 32'h99, 1, 32'h0,
               1'b1, 1'b1, 4'b1100, 32'h5678_5678, wb_t'{1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0});
        run_op("sb", 4'd6, 32'h1001, 32'h1234_5AA5, 1'b0, 5'd0, 32'h0, 2, 32'h0,
               1'b1, 1'b1, 4'b0010, 32'hA5A5_A5A5, wb_t'{1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0});
        run_op("lw_mis", 4'd3, 32'h3001, 32'h0, 1'b1, 5'd9, 32'h77, 0, 32'h0,
               1'b0, 1'b0, 4'h0, 32'h0, wb_t'{1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1});
        run_op("nop_after_mis", 4'd0, 32'h0, 32'h0, 1'b0, 5'd2, 32'h7, 0, 32'h0,
               1'b0, 1'b0, 4'h0, 32'h0, wb_t'{1'b0, 5'd2, 32'h7, 1'b0, 1'b0, 1'b1});
        run_op("lw_timeout", 4'd3, 32'h3000, 32'h0, 1'b1, 5'd10, 32'h5, 0, 32'h0,
               1'b1, 1'b0, 4'b1111, 32'h0, wb_t'{1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1});
        run_op("nop_after_err", 4'd15, 32'h0, 32'h0, 1'b1, 5'd4, 32'h44, 0, 32'h0,
               1'b0, 1'b0, 4'h0, 32'h0, wb_t'{1'b1, 5'd4, 32'h44, 1'b0, 1'b0, 1'b1});
        run_op("lw_ack_last", 4'd3, 32'h3004, 32'h0, 1'b1, 5'd10, 32'h5, TO, 32'h1357_9BDF,
               1'b1, 1'b0, 4'b1111, 32'h0, wb_t'{1'b1, 5'd10, 32'h1357_9BDF, 1'b0, 1'b0, 1'b1});
        run_op("lh", 4'd2, 32'h10, 32'h0, 1'b1, 5'd11, 32'h0, 2, 32'h1234_8001,
               1'b1, 1'b0, 4'b0011, 32'h0, wb_t'{1'b1, 5'd11, 32'hFFFF_8001, 1'b0, 1'b0, 1'b1});
        run_op("lhu", 4'd5, 32'h12, 32'h0, 1'b1, 5'd12, 32'h0, 1, 32'h8001_0000,
               1'b1, 1'b0, 4'b1100, 32'h0, wb_t'{1'b1, 5'd12, 32'h0000_8001, 1'b0, 1'b0, 1'b1});

        // Ack while idle must not disturb a pass-through.
        sb.push_back(wb_t'{1'b1, 5'd3, 32'h55, 1'b0, 1'b0, 1'b1});
        mem_op_i = 4'd0; reg_we_i = 1'b1; reg_waddr_i = 5'd3; reg_wdata_i = 32'h55;
        bus.ack = 1'b1; bus.rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus.ack = 1'b0;
        chk("idle_ack.req", 32'(bus.req), 32'd0);
        check_wb("idle_ack");

        // Reset during the second WAIT cycle.
        mem_op_i = 4'd3; mem_addr_i = 32'h5000; reg_we_i = 1'b1; reg_waddr_i = 5'd9;
        @(posedge clk); #1;
        chk("rst_wait.req1", 32'(bus.req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_wait.stall", 32'(stallreq), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_op_i = 4'd0; reg_we_i = 1'b0; reg_waddr_i = 5'd0; reg_wdata_i = 32'd0;
        chk("rst_wait.req", 32'(bus.req), 32'd0);
        chk("rst_wait.addr", bus.addr, 32'd0);
        chk("rst_wait.sel", 32'(bus.sel), 32'd0);
        chk("rst_wait.we", 32'(reg_we_o), 32'd0);
        chk("rst_wait.waddr", 32'(reg_waddr_o), 32'd0);
        @(posedge clk); #1;
        chk("rst_wait.no_wb", 32'(reg_we_o), 32'd0);

        run_op("sw", 4'd8, 32'h4000, 32'hCAFE_BABE, 1'b0, 5'd0, 32'h0, 1, 32'h0,
               1'b1, 1'b1, 4'b1111, 32'hCAFE_BABE, wb_t'{1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0});

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
